// File: rtl/fwht_sequency_reader.sv
// Reads one FWHT frame from the result RAM and streams it in sequency order.
// Optional build macro FWHT_ORDER_SEL_EN adds i_natural to select natural order per frame.
module fwht_sequency_reader #(
    parameter int L_WIDTH = 3,
    parameter int D_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_start,
`ifdef FWHT_ORDER_SEL_EN
    input  logic                      i_natural,
`endif
    output logic                      o_busy,
    output logic                      o_rd_en,
    output logic [L_WIDTH-1:0]        o_rd_addr,
    input  logic signed [D_WIDTH-1:0] i_rd_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic signed [D_WIDTH-1:0] o_data,
    output logic [L_WIDTH-1:0]        o_index,
    output logic                      o_last
);

    localparam logic [L_WIDTH-1:0] K_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Sequency index k -> natural address: Gray code, then bit reversal.
    function automatic logic [L_WIDTH-1:0] seq_addr(input logic [L_WIDTH-1:0] k);
        logic [L_WIDTH-1:0] g;
        logic [L_WIDTH-1:0] r;
        g = k ^ (k >> 1);
        for (int i = 0; i < L_WIDTH; i++) begin
            r[i] = g[L_WIDTH-1-i];
        end
        return r;
    endfunction

    state_t                     state_q, state_d;
    logic [L_WIDTH-1:0]         rk_q, rk_d;
    logic [L_WIDTH-1:0]         ok_q, ok_d;
    logic                       inflight_q, inflight_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic                       wr_ptr_q, wr_ptr_d;
    logic                       rd_ptr_q, rd_ptr_d;
    logic signed [D_WIDTH-1:0]  mem_q [2];
    logic signed [D_WIDTH-1:0]  mem_d [2];

    logic                       rd_en;
    logic                       head_valid;
    logic                       pop;
    logic                       push;
    logic                       credit;
    logic [L_WIDTH-1:0]         rd_addr;

`ifdef FWHT_ORDER_SEL_EN
    logic natural_q, natural_d;
    assign rd_addr = natural_q ? rk_q : seq_addr(rk_q);
`else
    assign rd_addr = seq_addr(rk_q);
`endif

    always_comb begin
        state_d    = state_q;
        rk_d       = rk_q;
        ok_d       = ok_q;
        rd_en      = 1'b0;
`ifdef FWHT_ORDER_SEL_EN
        natural_d  = natural_q;
`endif
        // The word returning from RAM counts as buffer content and is presented
        // combinationally when nothing older is stored (fall-through head).
        head_valid = (cnt_q != 2'd0) || inflight_q;
        pop        = head_valid && i_ready;
        push       = inflight_q;
        credit     = ({1'b0, cnt_q} + {2'b00, inflight_q}) < 3'd2;

        if (pop) begin
            ok_d = ok_q + L_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_RUN;
                    rk_d    = '0;
                    ok_d    = '0;
`ifdef FWHT_ORDER_SEL_EN
                    natural_d = i_natural;
`endif
                end
            end
            S_RUN: begin
                if (credit) begin
                    rd_en = 1'b1;
                    rk_d  = rk_q + L_WIDTH'(1);
                    if (rk_q == K_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && (ok_q == K_LAST)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        inflight_d = rd_en;
        cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d   = pop ? ~rd_ptr_q : rd_ptr_q;
        mem_d      = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = i_rd_data;
        end
    end

    // Control state: reset discards any read still in flight.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            rk_q       <= '0;
            ok_q       <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
`ifdef FWHT_ORDER_SEL_EN
            natural_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rk_q       <= rk_d;
            ok_q       <= ok_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
`ifdef FWHT_ORDER_SEL_EN
            natural_q  <= natural_d;
`endif
        end
    end

    // Skid storage: data only, contents are meaningless while empty.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_busy    = (state_q != S_IDLE);
    assign o_rd_en   = rd_en;
    assign o_rd_addr = rd_en ? rd_addr : '0;
    assign o_valid   = head_valid;
    assign o_data    = !head_valid ? '0 : ((cnt_q != 2'd0) ? mem_q[rd_ptr_q] : i_rd_data);
    assign o_index   = ok_q;
    assign o_last    = head_valid && (ok_q == K_LAST);

endmodule

// File: tb/tb_fwht_sequency_reader.sv
// Directed bench for fwht_sequency_reader: sequency order, backpressure, ignored starts, reset, L=4.
module tb_fwht_sequency_reader;

    logic               clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               ready = 1'b1;
    logic               rd_en;
    logic [2:0]         rd_addr;
    logic signed [15:0] rd_data = 16'sd0;
    logic               valid;
    logic signed [15:0] data;
    logic [2:0]         index;
    logic               last;
    logic               busy;

    logic               start4 = 1'b0;
    logic               ready4 = 1'b1;
    logic               rd_en4;
    logic [3:0]         rd_addr4;
    logic signed [15:0] rd_data4 = 16'sd0;
    logic               valid4;
    logic signed [15:0] data4;
    logic [3:0]         index4;
    logic               last4;
    logic               busy4;

`ifdef FWHT_ORDER_SEL_EN
    logic               natural = 1'b0;
    logic               natural4 = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] seq8  [8]  = '{3'd0, 3'd4, 3'd6, 3'd2, 3'd3, 3'd7, 3'd5, 3'd1};
    logic [3:0] seq16 [16] = '{4'd0, 4'd8, 4'd12, 4'd4, 4'd6, 4'd14, 4'd10, 4'd2,
                               4'd3, 4'd11, 4'd15, 4'd7, 4'd5, 4'd13, 4'd9, 4'd1};

    fwht_sequency_reader #(.L_WIDTH(3), .D_WIDTH(16)) u_dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_start   (start),
`ifdef FWHT_ORDER_SEL_EN
        .i_natural (natural),
`endif
        .o_busy    (busy),
        .o_rd_en   (rd_en),
        .o_rd_addr (rd_addr),
        .i_rd_data (rd_data),
        .o_valid   (valid),
        .i_ready   (ready),
        .o_data    (data),
        .o_index   (index),
        .o_last    (last)
    );

    fwht_sequency_reader #(.L_WIDTH(4), .D_WIDTH(16)) u_dut4 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_start   (start4),
`ifdef FWHT_ORDER_SEL_EN
        .i_natural (natural4),
`endif
        .o_busy    (busy4),
        .o_rd_en   (rd_en4),
        .o_rd_addr (rd_addr4),
        .i_rd_data (rd_data4),
        .o_valid   (valid4),
        .i_ready   (ready4),
        .o_data    (data4),
        .o_index   (index4),
        .o_last    (last4)
    );

    // RAM model: RAM[a] = 0x100 + a, one-cycle registered read.
    always @(posedge clk) begin
        if (rd_en) rd_data <= 16'sh0100 + $signed({13'd0, rd_addr});
    end

    function automatic logic signed [15:0] ram_val(input int a);
        return 16'(256 + a);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %0b want 0", rd_en); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", valid); end
        n_checks++; if (last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %0b want 0", last); end
        n_checks++; if (rd_addr !== 3'd0) begin n_fail++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end
        n_checks++; if (index !== 3'd0) begin n_fail++; $display("FAIL reset_index got %0d want 0", index); end
        n_checks++; if (data !== 16'sd0) begin n_fail++; $display("FAIL reset_data got %h want 0", data); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit exp_rd, exp_v, exp_busy;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            start = (c == 0); ready = 1'b1;
            #1;
            exp_rd   = (c >= 1 && c <= 8);
            exp_v    = (c >= 2 && c <= 9);
            exp_busy = (c >= 1 && c <= 9);
            n_checks++; if (rd_en !== exp_rd) begin n_fail++; $display("FAIL basic_rd_en c=%0d got %0b want %0b", c, rd_en, exp_rd); end
            if (exp_rd) begin
                n_checks++; if (rd_addr !== seq8[c-1]) begin n_fail++; $display("FAIL basic_rd_addr c=%0d got %0d want %0d", c, rd_addr, seq8[c-1]); end
            end
            n_checks++; if (valid !== exp_v) begin n_fail++; $display("FAIL basic_valid c=%0d got %0b want %0b", c, valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (data !== ram_val(int'(seq8[c-2]))) begin n_fail++; $display("FAIL basic_data c=%0d got %h want %h", c, data, ram_val(int'(seq8[c-2]))); end
                n_checks++; if (index !== 3'(c-2)) begin n_fail++; $display("FAIL basic_index c=%0d got %0d want %0d", c, index, c-2); end
            end
            n_checks++; if (last !== (c == 9)) begin n_fail++; $display("FAIL basic_last c=%0d got %0b want %0b", c, last, (c == 9)); end
            n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL basic_busy c=%0d got %0b want %0b", c, busy, exp_busy); end
        end
        start = 1'b0;
    endtask

    task automatic test_backpressure();
        int issued = 0;
        int acc = 0;
        bit held_v = 1'b0;
        logic signed [15:0] held_d = 16'sd0;
        logic [2:0] held_i = 3'd0;
        logic held_l = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            start = (c == 0);
            if (c < 3) ready = 1'b1;
            else if (c <= 6) ready = 1'b0;
            else ready = 1'($urandom_range(0, 1));
            #1;
            if (held_v) begin
                n_checks++;
                if (valid !== 1'b1 || data !== held_d || index !== held_i || last !== held_l) begin
                    n_fail++;
                    $display("FAIL bp_stable c=%0d got v=%0b d=%h i=%0d l=%0b want v=1 d=%h i=%0d l=%0b",
                             c, valid, data, index, last, held_d, held_i, held_l);
                end
            end
            if (rd_en) begin
                n_checks++;
                if (issued >= 8) begin n_fail++; $display("FAIL bp_extra_read c=%0d got read %0d want 8 max", c, issued + 1); end
                else if (rd_addr !== seq8[issued]) begin n_fail++; $display("FAIL bp_rd_addr c=%0d got %0d want %0d", c, rd_addr, seq8[issued]); end
                n_checks++;
                if (issued - acc >= 2) begin n_fail++; $display("FAIL bp_credit c=%0d got outstanding %0d want <2", c, issued - acc); end
                issued++;
            end
            if (valid && ready) begin
                n_checks++;
                if (acc >= 8) begin n_fail++; $display("FAIL bp_extra_beat c=%0d got beat %0d want 8 max", c, acc + 1); end
                else if (data !== ram_val(int'(seq8[acc])) || index !== 3'(acc) || last !== (acc == 7)) begin
                    n_fail++;
                    $display("FAIL bp_beat %0d got d=%h i=%0d l=%0b want d=%h i=%0d l=%0b",
                             acc, data, index, last, ram_val(int'(seq8[acc])), acc, (acc == 7));
                end
                acc++;
            end
            held_v = valid && !ready;
            held_d = data; held_i = index; held_l = last;
        end
        ready = 1'b1; start = 1'b0;
        n_checks++; if (acc !== 8) begin n_fail++; $display("FAIL bp_beat_count got %0d want 8", acc); end
        n_checks++; if (issued !== 8) begin n_fail++; $display("FAIL bp_read_count got %0d want 8", issued); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end got %0b want 0", busy); end
    endtask

    task automatic test_ignored_start();
        int beats = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            start = (c == 0 || c == 4 || c == 9); ready = 1'b1;
            #1;
            if (c == 9) begin
                n_checks++; if (!(valid && last && index == 3'd7)) begin n_fail++; $display("FAIL ign_final_beat got v=%0b l=%0b i=%0d want 1 1 7", valid, last, index); end
            end
            if (c >= 10) begin
                n_checks++; if (rd_en !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
                    n_fail++; $display("FAIL ign_restart c=%0d got rd=%0b busy=%0b v=%0b want 0 0 0", c, rd_en, busy, valid);
                end
            end
            if (valid && ready) begin
                n_checks++;
                if (beats >= 8 || data !== ram_val(int'(seq8[beats]))) begin n_fail++; $display("FAIL ign_beat %0d got %h", beats, data); end
                beats++;
            end
        end
        n_checks++; if (beats !== 8) begin n_fail++; $display("FAIL ign_beat_count got %0d want 8", beats); end
        beats = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            start = (c == 0); ready = 1'b1;
            #1;
            if (valid && ready) begin
                n_checks++;
                if (beats >= 8 || data !== ram_val(int'(seq8[beats])) || index !== 3'(beats)) begin
                    n_fail++; $display("FAIL fresh_beat %0d got d=%h i=%0d", beats, data, index);
                end
                beats++;
            end
        end
        start = 1'b0;
        n_checks++; if (beats !== 8) begin n_fail++; $display("FAIL fresh_beat_count got %0d want 8", beats); end
    endtask

    task automatic test_reset_mid_frame();
        int beats = 0;
        int reads = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            start = (c == 0);
            ready = (c != 5);
            rst_n = (c != 5);
            #1;
            if (c == 6 || c == 7) begin
                n_checks++;
                if (busy !== 1'b0 || rd_en !== 1'b0 || valid !== 1'b0 || last !== 1'b0 ||
                    rd_addr !== 3'd0 || index !== 3'd0 || data !== 16'sd0) begin
                    n_fail++;
                    $display("FAIL rst_mid_outputs c=%0d got busy=%0b rd=%0b v=%0b l=%0b a=%0d i=%0d d=%h want all 0",
                             c, busy, rd_en, valid, last, rd_addr, index, data);
                end
            end
            if (valid && ready && rst_n) beats++;
        end
        n_checks++; if (beats !== 3) begin n_fail++; $display("FAIL rst_mid_pre_beats got %0d want 3", beats); end
        rst_n = 1'b1;
        beats = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            start = (c == 0); ready = 1'b1;
            #1;
            if (rd_en) begin
                n_checks++;
                if (reads >= 8 || rd_addr !== seq8[reads]) begin n_fail++; $display("FAIL rst_new_addr %0d got %0d", reads, rd_addr); end
                reads++;
            end
            if (valid) begin
                n_checks++;
                if (beats >= 8 || data !== ram_val(int'(seq8[beats])) || index !== 3'(beats)) begin
                    n_fail++; $display("FAIL rst_new_beat %0d got d=%h i=%0d", beats, data, index);
                end
                beats++;
            end
        end
        start = 1'b0;
        n_checks++; if (beats !== 8) begin n_fail++; $display("FAIL rst_new_beat_count got %0d want 8", beats); end
    endtask

    task automatic test_l4();
        int reads = 0;
        int beats = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            start4 = (c == 0);
            #1;
            if (rd_en4) begin
                n_checks++;
                if (reads >= 16 || rd_addr4 !== seq16[reads]) begin n_fail++; $display("FAIL l4_addr %0d got %0d", reads, rd_addr4); end
                reads++;
            end
            if (valid4) begin
                n_checks++;
                if (index4 !== 4'(beats) || last4 !== (beats == 15) || data4 !== 16'sd0) begin
                    n_fail++; $display("FAIL l4_beat %0d got i=%0d l=%0b d=%h", beats, index4, last4, data4);
                end
                beats++;
            end
        end
        start4 = 1'b0;
        n_checks++; if (reads !== 16 || beats !== 16 || busy4 !== 1'b0) begin
            n_fail++; $display("FAIL l4_counts got reads=%0d beats=%0d busy=%0b want 16 16 0", reads, beats, busy4);
        end
    endtask

`ifdef FWHT_ORDER_SEL_EN
    task automatic test_natural();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            start = (c == 0); natural = (c == 0); ready = 1'b1;
            #1;
            if (c >= 1 && c <= 8) begin
                n_checks++; if (rd_en !== 1'b1 || rd_addr !== 3'(c-1)) begin n_fail++; $display("FAIL nat_addr c=%0d got %0d want %0d", c, rd_addr, c-1); end
            end
            if (c >= 2 && c <= 9) begin
                n_checks++; if (valid !== 1'b1 || data !== ram_val(c-2)) begin n_fail++; $display("FAIL nat_data c=%0d got %h want %h", c, data, ram_val(c-2)); end
            end
        end
        start = 1'b0; natural = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored_start();
        test_reset_mid_frame();
        test_l4();
`ifdef FWHT_ORDER_SEL_EN
        test_natural();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
